// File: rtl/fir_out_collector.sv
// FIR output collector: buffers the FIR result stream in a small FIFO
// and exposes it to a host through a read-mostly AXI-Lite register window.
module fir_out_collector #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 16
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    input  logic                   awvalid,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   awready,
    input  logic                   wvalid,
    input  logic [pDATA_WIDTH-1:0] wdata,
    output logic                   wready,
    input  logic                   arvalid,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   arready,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata
);

    localparam int PW = $clog2(pDEPTH);
    localparam int CW = PW + 1;

    localparam logic [pADDR_WIDTH-1:0] ADDR_STATUS = pADDR_WIDTH'('h00);
    localparam logic [pADDR_WIDTH-1:0] ADDR_POP    = pADDR_WIDTH'('h04);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TOTAL  = pADDR_WIDTH'('h08);

    // Each entry holds {tlast, tdata}
    logic [pDATA_WIDTH:0]   mem [pDEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic [31:0]            total;
    logic                   last_rx;
    logic                   underflow;
    logic                   aw_rdy;

    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   push_eff;
    logic                   rd_acc;
    logic                   wr_acc;
    logic                   flush;
    logic                   clr_total;
    logic                   pop_req;
    logic                   pop;
    logic                   head_last;
    logic [pDATA_WIDTH:0]   head;
    logic [pDATA_WIDTH-1:0] status;
    logic [pDATA_WIDTH-1:0] rd_mux;
    logic                   unused_wdata;

    assign full      = (count == CW'(pDEPTH));
    assign empty     = (count == '0);
    assign ss_tready = !full;
    assign push      = ss_tvalid && ss_tready;

    assign arready   = !rvalid;
    assign rd_acc    = arvalid && arready;

    assign awready   = aw_rdy;
    assign wready    = aw_rdy;
    assign wr_acc    = awvalid && wvalid && aw_rdy;

    // A flush wins over a same-cycle push: the sample is dropped
    assign flush     = wr_acc && (awaddr == ADDR_STATUS) && wdata[0];
    assign clr_total = flush && wdata[1];
    assign push_eff  = push && !flush;

    assign pop_req   = rd_acc && (araddr == ADDR_POP);
    assign pop       = pop_req && !empty;

    assign head      = mem[rd_ptr];
    assign head_last = !empty && head[pDATA_WIDTH];

    assign unused_wdata = ^wdata[pDATA_WIDTH-1:2];

    // Status word assembled from live state
    always_comb begin
        status       = '0;
        status[0]    = empty;
        status[1]    = full;
        status[2]    = last_rx;
        status[3]    = underflow;
        status[4]    = head_last;
        status[15:8] = 8'(count);
    end

    // Read data selected by the address presented at accept time
    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            (araddr == ADDR_STATUS): rd_mux = status;
            (araddr == ADDR_POP):    rd_mux = empty ? '0 : head[pDATA_WIDTH-1:0];
            (araddr == ADDR_TOTAL):  rd_mux = pDATA_WIDTH'(total);
            default:                 rd_mux = '0;
        endcase
    end

    // Sample storage, intentionally left unreset
    always_ff @(posedge axis_clk) begin
        if (axis_rst_n && push_eff) begin
            mem[wr_ptr] <= {ss_tlast, ss_tdata};
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_eff, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Accepted-sample counter, cleared only on explicit request
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n || clr_total) begin
            total <= '0;
        end else if (push_eff) begin
            total <= total + 32'd1;
        end
    end

    // Sticky flags for end-of-frame and empty-pop events
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n || flush) begin
            last_rx   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_eff && ss_tlast) begin
                last_rx <= 1'b1;
            end
            if (pop_req && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Read response register, held until the host takes it
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (rd_acc) begin
            rvalid <= 1'b1;
            rdata  <= rd_mux;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

    // Write ready pulses one cycle, then rests one cycle
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            aw_rdy <= 1'b0;
        end else begin
            aw_rdy <= awvalid && wvalid && !aw_rdy;
        end
    end

endmodule

// File: tb/tb_fir_out_collector.sv
// Bench for fir_out_collector: scenario tasks checked against a
// queue-based model of the collector.
module tb_fir_out_collector;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int DEPTH = 16;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n = 1'b0;
    logic          ss_tvalid = 1'b0;
    logic [DW-1:0] ss_tdata = '0;
    logic          ss_tlast = 1'b0;
    logic          ss_tready;
    logic          awvalid = 1'b0;
    logic [AW-1:0] awaddr = '0;
    logic          awready;
    logic          wvalid = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          wready;
    logic          arvalid = 1'b0;
    logic [AW-1:0] araddr = '0;
    logic          arready;
    logic          rvalid;
    logic          rready = 1'b0;
    logic [DW-1:0] rdata;

    int tests = 0;
    int fails = 0;

    logic [DW:0]   q[$];
    logic [31:0]   m_total;
    logic          m_last_rx;
    logic          m_underflow;

    fir_out_collector #(
        .pADDR_WIDTH(AW),
        .pDATA_WIDTH(DW),
        .pDEPTH(DEPTH)
    ) dut (
        .axis_clk(axis_clk),
        .axis_rst_n(axis_rst_n),
        .ss_tvalid(ss_tvalid),
        .ss_tdata(ss_tdata),
        .ss_tlast(ss_tlast),
        .ss_tready(ss_tready),
        .awvalid(awvalid),
        .awaddr(awaddr),
        .awready(awready),
        .wvalid(wvalid),
        .wdata(wdata),
        .wready(wready),
        .arvalid(arvalid),
        .araddr(araddr),
        .arready(arready),
        .rvalid(rvalid),
        .rready(rready),
        .rdata(rdata)
    );

    always #5 axis_clk = ~axis_clk;

    function automatic void m_reset();
        q.delete();
        m_total = '0;
        m_last_rx = 1'b0;
        m_underflow = 1'b0;
    endfunction

    function automatic void m_push(input logic [31:0] d, input logic l);
        q.push_back({l, d});
        m_total = m_total + 32'd1;
        if (l) m_last_rx = 1'b1;
    endfunction

    function automatic logic [31:0] m_pop();
        logic [32:0] e;
        if (q.size() == 0) begin
            m_underflow = 1'b1;
            return 32'h0;
        end
        e = q.pop_front();
        return e[31:0];
    endfunction

    function automatic void m_flush(input logic clr);
        q.delete();
        m_last_rx = 1'b0;
        m_underflow = 1'b0;
        if (clr) m_total = '0;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        logic [32:0] h;
        s = '0;
        s[0] = (q.size() == 0);
        s[1] = (q.size() == DEPTH);
        s[2] = m_last_rx;
        s[3] = m_underflow;
        if (q.size() != 0) begin
            h = q[0];
            s[4] = h[32];
        end
        s[15:8] = 8'(q.size());
        return s;
    endfunction

    task automatic push_s(input logic [31:0] d, input logic l);
        int n = 0;
        ss_tvalid = 1'b1;
        ss_tdata = d;
        ss_tlast = l;
        while (!ss_tready && n < 50) begin
            @(negedge axis_clk);
            n++;
        end
        tests++;
        if (n >= 50) begin
            fails++;
            $display("FAIL push_timeout ss_tready=%0b required 1", ss_tready);
        end else begin
            m_push(d, l);
        end
        @(negedge axis_clk);
        ss_tvalid = 1'b0;
        ss_tlast = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d);
        int n = 0;
        arvalid = 1'b1;
        araddr = a;
        while (!arready && n < 50) begin
            @(negedge axis_clk);
            n++;
        end
        @(negedge axis_clk);
        arvalid = 1'b0;
        while (!rvalid && n < 100) begin
            @(negedge axis_clk);
            n++;
        end
        tests++;
        if (!rvalid) begin
            fails++;
            $display("FAIL read_timeout addr=%h rvalid=%0b required 1", a, rvalid);
        end
        d = rdata;
        rready = 1'b1;
        @(negedge axis_clk);
        rready = 1'b0;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d);
        int n = 0;
        awvalid = 1'b1;
        wvalid = 1'b1;
        awaddr = a;
        wdata = d;
        while (!(awready && wready) && n < 50) begin
            @(negedge axis_clk);
            n++;
        end
        tests++;
        if (n >= 50) begin
            fails++;
            $display("FAIL write_timeout awready=%0b wready=%0b required 1", awready, wready);
        end
        @(negedge axis_clk);
        awvalid = 1'b0;
        wvalid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        axis_rst_n = 1'b0;
        repeat (2) @(negedge axis_clk);
        tests++;
        if (rvalid !== 1'b0 || awready !== 1'b0 || wready !== 1'b0) begin
            fails++;
            $display("FAIL reset_outs rvalid=%0b awready=%0b wready=%0b required 0", rvalid, awready, wready);
        end
        tests++;
        if (arready !== 1'b1 || ss_tready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready arready=%0b ss_tready=%0b required 1", arready, ss_tready);
        end
        axis_rst_n = 1'b1;
        m_reset();
        axi_read(12'h000, got);
        tests++;
        if (got !== 32'h0000_0001) begin
            fails++;
            $display("FAIL reset_status got=%h required 00000001", got);
        end
        axi_read(12'h008, got);
        tests++;
        if (got !== 32'h0) begin
            fails++;
            $display("FAIL reset_total got=%h required 0", got);
        end
    endtask

    task automatic test_basic();
        logic [31:0] vals [3];
        logic [31:0] got;
        logic [31:0] exp;
        vals[0] = 32'(-10);
        vals[1] = 32'd23;
        vals[2] = 32'd56;
        for (int i = 0; i < 3; i++) push_s(vals[i], i == 2);
        for (int i = 0; i < 3; i++) begin
            exp = m_pop();
            axi_read(12'h004, got);
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL basic_pop%0d got=%h required %h", i, got, exp);
            end
        end
        axi_read(12'h000, got);
        tests++;
        if (got !== m_status()) begin
            fails++;
            $display("FAIL basic_status got=%h required %h", got, m_status());
        end
        axi_read(12'h008, got);
        tests++;
        if (got !== m_total) begin
            fails++;
            $display("FAIL basic_total got=%0d required %0d", got, m_total);
        end
    endtask

    task automatic test_full();
        logic [31:0] got;
        logic [31:0] exp;
        for (int i = 0; i < DEPTH; i++) push_s($urandom, 1'b0);
        tests++;
        if (ss_tready !== 1'b0) begin
            fails++;
            $display("FAIL full_tready got=%0b required 0", ss_tready);
        end
        axi_read(12'h000, got);
        tests++;
        if (got !== m_status()) begin
            fails++;
            $display("FAIL full_status got=%h required %h", got, m_status());
        end
        exp = m_pop();
        arvalid = 1'b1;
        araddr = 12'h004;
        @(negedge axis_clk);
        arvalid = 1'b0;
        tests++;
        if (ss_tready !== 1'b1) begin
            fails++;
            $display("FAIL full_ready_after_pop got=%0b required 1", ss_tready);
        end
        tests++;
        if (rvalid !== 1'b1 || rdata !== exp) begin
            fails++;
            $display("FAIL full_pop rvalid=%0b rdata=%h required %h", rvalid, rdata, exp);
        end
        rready = 1'b1;
        @(negedge axis_clk);
        rready = 1'b0;
        push_s($urandom, 1'b0);
        axi_read(12'h000, got);
        tests++;
        if (got !== m_status()) begin
            fails++;
            $display("FAIL full_status17 got=%h required %h", got, m_status());
        end
        for (int i = 0; i < DEPTH; i++) begin
            exp = m_pop();
            axi_read(12'h004, got);
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL full_drain%0d got=%h required %h", i, got, exp);
            end
        end
    endtask

    task automatic test_underflow_flush();
        logic [31:0] got;
        logic [31:0] exp;
        exp = m_pop();
        axi_read(12'h004, got);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL uf_data got=%h required %h", got, exp);
        end
        axi_read(12'h000, got);
        tests++;
        if (got !== m_status()) begin
            fails++;
            $display("FAIL uf_status got=%h required %h", got, m_status());
        end
        axi_write(12'h000, 32'h1);
        m_flush(1'b0);
        axi_read(12'h000, got);
        tests++;
        if (got !== m_status()) begin
            fails++;
            $display("FAIL flush_status got=%h required %h", got, m_status());
        end
        axi_read(12'h008, got);
        tests++;
        if (got !== m_total) begin
            fails++;
            $display("FAIL flush_keep_total got=%0d required %0d", got, m_total);
        end
        axi_write(12'h000, 32'h3);
        m_flush(1'b1);
        axi_read(12'h008, got);
        tests++;
        if (got !== m_total) begin
            fails++;
            $display("FAIL flush_clr_total got=%0d required %0d", got, m_total);
        end
    endtask

    task automatic test_write_handshake();
        logic [31:0] got;
        int pulses = 0;
        push_s($urandom, 1'b1);
        push_s($urandom, 1'b0);
        awvalid = 1'b1;
        awaddr = 12'h010;
        @(negedge axis_clk);
        tests++;
        if (awready !== 1'b0) begin
            fails++;
            $display("FAIL aw_only_ready got=%0b required 0", awready);
        end
        wvalid = 1'b1;
        wdata = 32'h3;
        for (int i = 0; i < 8; i++) begin
            @(negedge axis_clk);
            tests++;
            if (awready !== (i % 2 == 0) || wready !== awready) begin
                fails++;
                $display("FAIL wr_pulse%0d awready=%0b wready=%0b required %0b", i, awready, wready, i % 2 == 0);
            end
            if (awready) pulses++;
        end
        awvalid = 1'b0;
        wvalid = 1'b0;
        tests++;
        if (pulses != 4) begin
            fails++;
            $display("FAIL wr_pulse_count got=%0d required 4", pulses);
        end
        axi_write(12'h000, 32'h0);
        axi_write(12'h004, 32'h1);
        axi_read(12'h000, got);
        tests++;
        if (got !== m_status()) begin
            fails++;
            $display("FAIL wr_ignored_status got=%h required %h", got, m_status());
        end
    endtask

    task automatic test_flush_collide();
        logic [31:0] got;
        logic [31:0] exp;
        push_s($urandom, 1'b0);
        push_s($urandom, 1'b1);
        awvalid = 1'b1;
        wvalid = 1'b1;
        awaddr = 12'h000;
        wdata = 32'h1;
        @(negedge axis_clk);
        tests++;
        if (awready !== 1'b1) begin
            fails++;
            $display("FAIL collide_awready got=%0b required 1", awready);
        end
        arvalid = 1'b1;
        araddr = 12'h004;
        ss_tvalid = 1'b1;
        ss_tdata = $urandom;
        tests++;
        if (ss_tready !== 1'b1) begin
            fails++;
            $display("FAIL collide_tready got=%0b required 1", ss_tready);
        end
        exp = q[0][31:0];
        m_flush(1'b0);
        @(negedge axis_clk);
        awvalid = 1'b0;
        wvalid = 1'b0;
        arvalid = 1'b0;
        ss_tvalid = 1'b0;
        tests++;
        if (rvalid !== 1'b1 || rdata !== exp) begin
            fails++;
            $display("FAIL collide_pop rvalid=%0b rdata=%h required %h", rvalid, rdata, exp);
        end
        rready = 1'b1;
        @(negedge axis_clk);
        rready = 1'b0;
        axi_read(12'h000, got);
        tests++;
        if (got !== m_status()) begin
            fails++;
            $display("FAIL collide_status got=%h required %h", got, m_status());
        end
        axi_read(12'h008, got);
        tests++;
        if (got !== m_total) begin
            fails++;
            $display("FAIL collide_total got=%0d required %0d", got, m_total);
        end
    endtask

    task automatic test_stream();
        logic [31:0] smp [600];
        logic [31:0] exp_rd;
        logic [31:0] got;
        logic [AW-1:0] a;
        int sent = 0;
        int cyc = 0;
        int pre;
        bit busy = 0;
        bit issue;
        bit done;
        axi_write(12'h000, 32'h3);
        m_flush(1'b1);
        foreach (smp[i]) smp[i] = $urandom;
        exp_rd = '0;
        while ((sent < 600 || q.size() != 0 || busy) && cyc < 20000) begin
            issue = 0;
            done = 0;
            pre = q.size();
            arvalid = 1'b0;
            if (busy) begin
                tests++;
                if (rvalid !== 1'b1) begin
                    fails++;
                    $display("FAIL stream_rvalid cyc=%0d got=%0b required 1", cyc, rvalid);
                end
                rready = ($urandom_range(3) != 0);
                if (rready) begin
                    done = 1;
                    tests++;
                    if (rdata !== exp_rd) begin
                        fails++;
                        $display("FAIL stream_rdata cyc=%0d got=%h required %h", cyc, rdata, exp_rd);
                    end
                end
            end else begin
                rready = 1'b0;
                if ($urandom_range(3) != 0) begin
                    issue = 1;
                    a = ($urandom_range(3) == 0) ? 12'h000 : 12'h004;
                    tests++;
                    if (arready !== 1'b1) begin
                        fails++;
                        $display("FAIL stream_arready cyc=%0d got=%0b required 1", cyc, arready);
                    end
                    arvalid = 1'b1;
                    araddr = a;
                    exp_rd = (a == 12'h000) ? m_status() : m_pop();
                end
            end
            if (sent < 600 && $urandom_range(3) != 0) begin
                ss_tvalid = 1'b1;
                ss_tdata = smp[sent];
                ss_tlast = (sent == 599);
                tests++;
                if (ss_tready !== (pre != DEPTH)) begin
                    fails++;
                    $display("FAIL stream_tready cyc=%0d got=%0b required %0b", cyc, ss_tready, pre != DEPTH);
                end
                if (pre != DEPTH) begin
                    m_push(smp[sent], sent == 599);
                    sent++;
                end
            end else begin
                ss_tvalid = 1'b0;
                ss_tlast = 1'b0;
            end
            @(negedge axis_clk);
            cyc++;
            if (issue) busy = 1;
            if (done) busy = 0;
        end
        arvalid = 1'b0;
        rready = 1'b0;
        ss_tvalid = 1'b0;
        ss_tlast = 1'b0;
        tests++;
        if (cyc >= 20000) begin
            fails++;
            $display("FAIL stream_timeout sent=%0d left=%0d required 600 and 0", sent, q.size());
        end
        axi_read(12'h008, got);
        tests++;
        if (got !== m_total) begin
            fails++;
            $display("FAIL stream_total got=%0d required %0d", got, m_total);
        end
        axi_read(12'h000, got);
        tests++;
        if (got !== m_status()) begin
            fails++;
            $display("FAIL stream_status got=%h required %h", got, m_status());
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        logic [31:0] exp;
        for (int i = 0; i < 5; i++) push_s($urandom, 1'b0);
        arvalid = 1'b1;
        araddr = 12'h000;
        @(negedge axis_clk);
        arvalid = 1'b0;
        tests++;
        if (rvalid !== 1'b1) begin
            fails++;
            $display("FAIL mid_rvalid_pre got=%0b required 1", rvalid);
        end
        axis_rst_n = 1'b0;
        @(negedge axis_clk);
        tests++;
        if (rvalid !== 1'b0 || ss_tready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset rvalid=%0b ss_tready=%0b required 0 1", rvalid, ss_tready);
        end
        axis_rst_n = 1'b1;
        m_reset();
        axi_read(12'h000, got);
        tests++;
        if (got !== m_status()) begin
            fails++;
            $display("FAIL mid_status got=%h required %h", got, m_status());
        end
        push_s($urandom, 1'b0);
        exp = m_pop();
        axi_read(12'h004, got);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL mid_new_pop got=%h required %h", got, exp);
        end
        axi_read(12'h008, got);
        tests++;
        if (got !== m_total) begin
            fails++;
            $display("FAIL mid_total got=%0d required %0d", got, m_total);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        m_reset();
        test_reset();
        test_basic();
        test_full();
        test_underflow_flush();
        test_write_handshake();
        test_flush_collide();
        test_stream();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
